chan_merge_top: RTL and testbench
=================================

# chan_merge_top

Parametrised multi-channel top that instantiates `NUM_CH` identical buffered channel sub-modules and merges them onto one output stream through a round-robin arbiter. It is the sequential, width/count-generalised successor of the fixed three-instance nested-submodule top. It serves as a nested-hierarchy test and demonstration block.

## Interface
Parameters:
- `NUM_CH`, default 4: number of input channels, 2..16.
- `DATA_W`, default 8: payload width per channel, 1..64.
- `DEPTH`, default 4: FIFO entries per channel; power of two, ≥2.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in `NUM_CH`: per-channel word offered.
- `in_ready` out `NUM_CH`: per-channel FIFO not full.
- `in_data` in `NUM_CH*DATA_W`: channel k occupies bits `[k*DATA_W +: DATA_W]`.
- `out_valid` out 1: output register holds a word.
- `out_ready` in 1: downstream accepts.
- `out_data` out `DATA_W`: merged payload.
- `out_ch` out `CH_W` = clog2(`NUM_CH`): source channel of `out_data`.
- `fifo_empty` out `NUM_CH`: per-channel empty flag.

Clocking and reset: one clock; reset is asynchronous and active-high.

## Operation
- Each channel instance (`chan_fifo`) is a `DEPTH`-entry FIFO.
  - Push when `in_valid[k] & in_ready[k]`.
  - `in_ready[k]` = !full, taken from the registered count. No combinational path from `out_ready`.
- Output register is loadable when `!out_valid | out_ready`.
  - When loadable and at least one FIFO is non-empty, the arbiter grants one channel.
  - The granted channel's head word pops into `out_data`, and `out_ch` is set to that channel.
  - When loadable and all FIFOs are empty, `out_valid` clears.
- Round-robin arbitration:
  - The pointer `rr` holds the highest-priority channel.
  - Search order is `rr`, `rr+1`, … mod `NUM_CH`.
  - After a grant to channel g, `rr` becomes (g+1) mod `NUM_CH`.
  - With no grant, `rr` is unchanged.
- While `out_valid & !out_ready`, `out_data` and `out_ch` are held stable and no pop occurs.
- FIFO boundaries:
  - Full: `in_ready` is low; a word offered on `in_valid` is not taken and stays upstream.
  - Pop and push in the same cycle on a non-full FIFO: both occur and the count is unchanged.
  - Empty plus push: the word becomes visible to the arbiter on the next cycle. There is no fall-through.
- Pointers wrap modulo `DEPTH`. Count width is clog2(`DEPTH`)+1.
- Reset, including mid-transfer:
  - All FIFOs are flushed (pointers and counts 0). In-flight data is discarded.
  - `rr` = 0.
  - `out_valid` = 0, `out_data` = 0, `out_ch` = 0.
  - `in_ready` = all ones; `fifo_empty` = all ones.

## Timing
- Push sampled at edge T → word at FIFO head after T → granted at edge T+1 → `out_valid` high after T+1. Minimum latency is 2 cycles.
- Sustained throughput is 1 word/cycle when `out_ready` is held high and any FIFO is non-empty.
- `in_ready` deasserts in the cycle after the push that fills the FIFO. It reasserts in the cycle after the pop that frees an entry.
- All outputs are registered except `in_ready` and `fifo_empty`, which decode registered state only.

## Configuration
- `CHAN_MERGE_CNT_EN`
  - Defined: adds output `grant_cnt` (`NUM_CH*16` bits). It holds one 16-bit saturating counter per channel.
    - The counter increments on each grant to that channel and sticks at 16'hFFFF.
    - It is cleared by `rst`.
  - Undefined: the port and counters are absent. All other behaviour is identical.

## Structure
- Shared package `chan_merge_pkg` holds:
  - the `clog2` function;
  - the `CNT_W` = 16 constant;
  - the `CNT_MAX` constant.
- Sub-module `chan_fifo` (params `DATA_W`, `DEPTH`; ports `clk`, `rst`, push/pop, data, full, empty) is instantiated `NUM_CH` times with a generate loop.
- The arbiter and output register stay in `chan_merge_top`.

## Test plan
- Reset: assert `rst` mid-stream with 3 words queued in ch1.
  - All FIFOs are empty, `out_valid` = 0, `out_data` = 0, `in_ready` = 4'b1111.
  - The first post-reset grant goes to ch0 if ch0 has a word.
- Latency: with defaults, push 8'hA5 on ch2 at edge T.
  - `out_valid` = 1, `out_data` = 8'hA5, `out_ch` = 2 after edge T+1.
- Fairness: all 4 channels hold 2 words, `out_ready` = 1.
  - `out_ch` sequence is 0,1,2,3,0,1,2,3; then `out_valid` = 0.
- Backpressure: `out_ready` = 0 for 10 cycles while ch0 pushes 8'h01..8'h05.
  - `out_data` is held. `in_ready[0]` drops after the 4th accepted word (8'h04).
  - 8'h05 is accepted once `out_ready` rises and ch0 pops.
- Simultaneous push and pop on ch3 at count 2 for 20 cycles: count stays 2 and data order is preserved.
- With `CHAN_MERGE_CNT_EN`: 70000 grants to ch1 → `grant_cnt[31:16]` = 16'hFFFF.

Source files
------------

// File: rtl/chan_merge_pkg.sv
// Shared definitions for the chan_merge hierarchy: ceiling-log2 helper and
// the grant-counter width/saturation constants used by the optional
// per-channel grant counters (enabled with CHAN_MERGE_CNT_EN).
package chan_merge_pkg;

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Ceiling log2, minimum result 1 so a one-bit index is always available.
  function automatic int clog2(input int value);
    int result;
    result = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/chan_fifo.sv
// Single-clock DEPTH-entry FIFO used as one input channel of chan_merge_top.
// The head word is presented on rd_data whenever the FIFO is non-empty; a
// word pushed into an empty FIFO is visible only after the push edge.
module chan_fifo
  import chan_merge_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W  = clog2(DEPTH);
  localparam int FILL_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [FILL_W-1:0] count;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == FILL_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage write; pointers wrap naturally because DEPTH is a power of two.
  // NOTE: the data array carries no reset -- validity is tracked by count,
  // so flushing the pointers is enough and the array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Pointer and occupancy bookkeeping; simultaneous push and pop keep count.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/chan_merge_top.sv
// NUM_CH buffered input channels merged onto one registered output stream by
// a round-robin arbiter. Optional per-channel saturating grant counters are
// added when the macro CHAN_MERGE_CNT_EN is defined.
module chan_merge_top
  import chan_merge_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH-1:0]          in_valid,
  output logic [NUM_CH-1:0]          in_ready,
  input  logic [NUM_CH*DATA_W-1:0]   in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [clog2(NUM_CH)-1:0]   out_ch,
  output logic [NUM_CH-1:0]          fifo_empty
`ifdef CHAN_MERGE_CNT_EN
  ,
  output logic [NUM_CH*CNT_W-1:0]    grant_cnt
`endif
);

  localparam int CH_W = clog2(NUM_CH);

  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] pop;
  logic [DATA_W-1:0] head [NUM_CH];
  logic [CH_W-1:0]   rr;
  logic [CH_W-1:0]   grant_idx;
  logic              grant_valid;
  logic              loadable;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    chan_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (in_valid[k]),
      .pop     (pop[k]),
      .wr_data (in_data[k*DATA_W +: DATA_W]),
      .rd_data (head[k]),
      .full    (full[k]),
      .empty   (empty[k])
    );
  end

  assign in_ready   = ~full;
  assign fifo_empty = empty;
  assign loadable   = !out_valid || out_ready;

  // Round-robin search: first non-empty channel starting at rr.
  // NOTE: every variable driven here gets a default first so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!grant_valid && !empty[(int'(rr) + i) % NUM_CH]) begin
        grant_valid = 1'b1;
        grant_idx   = CH_W'((int'(rr) + i) % NUM_CH);
      end
    end
  end

  // Pop the granted channel only when the output register can take its word.
  always_comb begin
    pop = '0;
    if (loadable && grant_valid) pop[grant_idx] = 1'b1;
  end

  // Output register and priority pointer; held while stalled downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      rr        <= '0;
    end else if (loadable) begin
      if (grant_valid) begin
        out_valid <= 1'b1;
        out_data  <= head[grant_idx];
        out_ch    <= grant_idx;
        rr        <= (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef CHAN_MERGE_CNT_EN
  logic [CNT_W-1:0] gcnt [NUM_CH];

  for (genvar k = 0; k < NUM_CH; k++) begin : g_cnt
    // Saturating count of grants to this channel.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        gcnt[k] <= '0;
      end else if (pop[k] && gcnt[k] != CNT_MAX) begin
        gcnt[k] <= gcnt[k] + 1'b1;
      end
    end
    assign grant_cnt[k*CNT_W +: CNT_W] = gcnt[k];
  end
`endif

endmodule

// File: tb/tb_chan_merge_top.sv
// Self-checking bench for chan_merge_top (default parameters). A queue-based
// reference model tracks per-channel contents, the priority pointer and the
// output register; directed steps plus a random phase are compared against it.
// Build with CHAN_MERGE_CNT_EN to also exercise the grant counters.
module tb_chan_merge_top;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
  logic [3:0]  fifo_empty;
`ifdef CHAN_MERGE_CNT_EN
  logic [63:0] grant_cnt;
`endif

  chan_merge_top #(
    .NUM_CH (NUM_CH),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_ch     (out_ch),
    .fifo_empty (fifo_empty)
`ifdef CHAN_MERGE_CNT_EN
    ,
    .grant_cnt  (grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  logic [7:0] q [NUM_CH][$];
  int         rr_m;
  logic       ov_m;
  logic [7:0] od_m;
  int         och_m;
  int         gcnt_m [NUM_CH];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < NUM_CH; k++) begin
      q[k].delete();
      gcnt_m[k] = 0;
    end
    rr_m  = 0;
    ov_m  = 1'b0;
    od_m  = '0;
    och_m = 0;
  endtask

  // Asynchronous reset applied between clock edges; checks the flushed state.
  task automatic do_reset();
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_clear();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_ch", out_ch, 0);
    chk("rst_in_ready", in_ready, 4'b1111);
    chk("rst_fifo_empty", fifo_empty, 4'b1111);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock cycle: drive at negedge, check decoded flags, advance model at
  // posedge, check registered outputs at the following negedge.
  task automatic step(input logic [3:0] v, input logic [31:0] d, input logic ordy);
    logic [3:0] exp_rdy;
    logic [3:0] exp_emp;
    logic [3:0] acc;
    logic       load;
    int         g;
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    #1;
    for (int k = 0; k < NUM_CH; k++) begin
      exp_rdy[k] = (q[k].size() < DEPTH);
      exp_emp[k] = (q[k].size() == 0);
      acc[k]     = v[k] && exp_rdy[k];
    end
    chk("in_ready", in_ready, exp_rdy);
    chk("fifo_empty", fifo_empty, exp_emp);
    load = !ov_m || ordy;
    g = -1;
    if (load) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (g < 0 && q[(rr_m + i) % NUM_CH].size() > 0) g = (rr_m + i) % NUM_CH;
      end
    end
    @(posedge clk);
    if (load) begin
      if (g >= 0) begin
        od_m  = q[g].pop_front();
        och_m = g;
        ov_m  = 1'b1;
        rr_m  = (g + 1) % NUM_CH;
        if (gcnt_m[g] < 65535) gcnt_m[g]++;
      end else begin
        ov_m = 1'b0;
      end
    end
    for (int k = 0; k < NUM_CH; k++) begin
      if (acc[k]) q[k].push_back(d[k*8 +: 8]);
    end
    @(negedge clk);
    chk("out_valid", out_valid, ov_m);
    if (ov_m) begin
      chk("out_data", out_data, od_m);
      chk("out_ch", out_ch, och_m);
    end
  endtask

  initial begin
    logic [7:0] w;
    logic       took;
    rst       = 1'b1;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    chk("init_out_valid", out_valid, 0);
    chk("init_in_ready", in_ready, 4'b1111);
    rst = 1'b0;

    // Mid-stream reset: one word in the output register, three queued on ch1.
    step(4'b0010, 32'h0000_B000, 1'b0);
    step(4'b0010, 32'h0000_B100, 1'b0);
    step(4'b0010, 32'h0000_B200, 1'b0);
    step(4'b0010, 32'h0000_B300, 1'b0);
    chk("pre_rst_fifo_empty", fifo_empty, 4'b1101);
    do_reset();
    step(4'b0011, 32'h0000_C1C0, 1'b1);
    step(4'b0000, 32'h0, 1'b1);
    chk("post_rst_grant_ch", out_ch, 0);
    chk("post_rst_grant_data", out_data, 8'hC0);
    step(4'b0000, 32'h0, 1'b1);
    step(4'b0000, 32'h0, 1'b1);

    // Minimum latency: push on ch2 at edge T, visible after edge T+1.
    do_reset();
    step(4'b0100, 32'h00A5_0000, 1'b1);
    chk("lat_not_yet", out_valid, 0);
    step(4'b0000, 32'h0, 1'b1);
    chk("lat_valid", out_valid, 1);
    chk("lat_data", out_data, 8'hA5);
    chk("lat_ch", out_ch, 2);
    step(4'b0000, 32'h0, 1'b1);

    // Fairness: two words per channel drain as 0,1,2,3,0,1,2,3.
    do_reset();
    step(4'b1111, 32'h3020_1000, 1'b0);
    step(4'b1111, 32'h3121_1101, 1'b0);
    for (int i = 0; i < 8; i++) begin
      chk("fair_valid", out_valid, 1);
      chk("fair_ch", out_ch, i % 4);
      step(4'b0000, 32'h0, 1'b1);
    end
    chk("fair_drained", out_valid, 0);

    // Backpressure: output holds 8'hEE from ch1 while ch0 fills.
    do_reset();
    step(4'b0010, 32'h0000_EE00, 1'b0);
    step(4'b0000, 32'h0, 1'b0);
    w = 8'h01;
    for (int c = 0; c < 10; c++) begin
      took = (q[0].size() < DEPTH);
      step(4'b0001, {24'h0, w}, 1'b0);
      chk("bp_hold_data", out_data, 8'hEE);
      chk("bp_hold_ch", out_ch, 1);
      if (took) w = w + 8'h01;
    end
    chk("bp_full", in_ready[0], 0);
    chk("bp_fifo_words", q[0].size(), 4);
    for (int c = 0; c < 10 && w == 8'h05; c++) begin
      took = (q[0].size() < DEPTH);
      step(4'b0001, {24'h0, w}, 1'b1);
      if (took) w = w + 8'h01;
    end
    chk("bp_word5_taken", w, 8'h06);
    repeat (6) step(4'b0000, 32'h0, 1'b1);
    chk("bp_drained", out_valid, 0);

    // Simultaneous push and pop on ch3 at count 2.
    do_reset();
    step(4'b1000, 32'h3000_0000, 1'b0);
    step(4'b1000, 32'h3100_0000, 1'b0);
    step(4'b1000, 32'h3200_0000, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(4'b1000, {8'h33 + 8'(i), 24'h0}, 1'b1);
      chk("pp_count", q[3].size(), 2);
    end
    repeat (4) step(4'b0000, 32'h0, 1'b1);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step(4'($urandom), $urandom, ($urandom_range(0, 9) < 7));
    end
    repeat (20) step(4'b0000, 32'h0, 1'b1);
    chk("rand_drained", out_valid, 0);

`ifdef CHAN_MERGE_CNT_EN
    // Grant counter saturation on ch1.
    do_reset();
    for (int i = 0; i < 70000; i++) begin
      step(4'b0010, $urandom, 1'b1);
    end
    chk("cnt_ch1_sat", grant_cnt[31:16], 16'hFFFF);
    chk("cnt_model", grant_cnt[31:16], gcnt_m[1]);
    chk("cnt_ch0", grant_cnt[15:0], gcnt_m[0]);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
